// File: rtl/vga_pkg.sv
// Shared VGA constants and the {R,G,B} word packing used between the
// framebuffer and the pixel pipeline.
package vga_pkg;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned FB_ADDR_BIT = 19;
  localparam int unsigned COLOR_BIT   = 4;

  // Channel slot counted from the LSB of a framebuffer word: {R,G,B}.
  typedef enum logic [1:0] {
    CH_B = 2'd0,
    CH_G = 2'd1,
    CH_R = 2'd2
  } rgb_chan_e;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } sync_tap_t;

endpackage

// File: rtl/pixel_fetch_delayN.sv
// Fixed-depth shift register; every stage clears to zero on reset.
module delayN #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/pixel_fetch.sv
// Framebuffer fetch and pin realignment: issues one read per visible pixel and
// delays sync to match the read latency; also tracks frame starts.
module pixel_fetch
  import vga_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COLOR_BIT    = 4,
  parameter int unsigned ADDR_BIT     = 19
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_hsync_en,
  input  logic                   i_haddr_en,
  input  logic [9:0]             i_hidx,
  input  logic                   i_vsync_en,
  input  logic                   i_vaddr_en,
  input  logic [8:0]             i_vidx,
  output logic                   o_rd_en,
  output logic [ADDR_BIT-1:0]    o_rd_addr,
  input  logic [3*COLOR_BIT-1:0] i_rd_data,
  output logic                   o_vga_hs,
  output logic                   o_vga_vs,
  output logic [COLOR_BIT-1:0]   o_r,
  output logic [COLOR_BIT-1:0]   o_g,
  output logic [COLOR_BIT-1:0]   o_b,
  output logic                   o_frame_start,
  output logic [7:0]             o_frame_cnt
);

  logic                w_active;
  logic [ADDR_BIT-1:0] w_row;
  logic [ADDR_BIT-1:0] w_addr;
  sync_tap_t           w_tap_in;
  sync_tap_t           w_tap_out;
  logic                r_vs_prev;

  always_comb begin
    w_active = i_haddr_en & i_vaddr_en &
               (i_hidx < 10'(H_VISIBLE)) & (i_vidx < 9'(V_VISIBLE));
    // row*640 as row*512 + row*128 keeps the multiply in plain adders
    w_row    = ADDR_BIT'(i_vidx);
    w_addr   = (w_row << 9) + (w_row << 7) + ADDR_BIT'(i_hidx);
    w_tap_in = '{active: w_active, hs: i_hsync_en, vs: i_vsync_en};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_en   <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      o_rd_en <= w_active;
      if (w_active) o_rd_addr <= w_addr;
    end
  end

  delayN #(
    .WIDTH($bits(sync_tap_t)),
    .DEPTH(READ_LATENCY + 1)
  ) u_sync_delay (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .i_d    (w_tap_in),
    .o_q    (w_tap_out)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vga_hs <= 1'b1;
      o_vga_vs <= 1'b1;
      o_r      <= '0;
      o_g      <= '0;
      o_b      <= '0;
    end else begin
      o_vga_hs <= ~w_tap_out.hs;
      o_vga_vs <= ~w_tap_out.vs;
      if (w_tap_out.active) begin
        o_r <= i_rd_data[int'(CH_R)*COLOR_BIT +: COLOR_BIT];
        o_g <= i_rd_data[int'(CH_G)*COLOR_BIT +: COLOR_BIT];
        o_b <= i_rd_data[int'(CH_B)*COLOR_BIT +: COLOR_BIT];
      end else begin
        o_r <= '0;
        o_g <= '0;
        o_b <= '0;
      end
    end
  end

  // Frame start follows the raw vsync rise, not the pin-aligned copy.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_prev     <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      r_vs_prev     <= i_vsync_en;
      o_frame_start <= i_vsync_en & ~r_vs_prev;
      if (i_vsync_en & ~r_vs_prev) o_frame_cnt <= o_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch at READ_LATENCY 1 and 3, driven side by side and
// checked against a cycle-history reference model plus a simple RAM model.
module tb_pixel_fetch;

  localparam int HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, hs_en, haddr_en, vs_en, vaddr_en;
  logic [9:0] hidx;
  logic [8:0] vidx;

  logic        rd_en_1, rd_en_3, hs_1, hs_3, vs_1, vs_3, fs_1, fs_3;
  logic [18:0] rd_addr_1, rd_addr_3;
  logic [11:0] rd_data_1, rd_data_3, rgb_1, rgb_3;
  logic [3:0]  r_1, g_1, b_1, r_3, g_3, b_3;
  logic [7:0]  cnt_1, cnt_3;

  assign rgb_1 = {r_1, g_1, b_1};
  assign rgb_3 = {r_3, g_3, b_3};

  pixel_fetch #(.READ_LATENCY(1), .COLOR_BIT(4), .ADDR_BIT(19)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n),
    .i_hsync_en(hs_en), .i_haddr_en(haddr_en), .i_hidx(hidx),
    .i_vsync_en(vs_en), .i_vaddr_en(vaddr_en), .i_vidx(vidx),
    .o_rd_en(rd_en_1), .o_rd_addr(rd_addr_1), .i_rd_data(rd_data_1),
    .o_vga_hs(hs_1), .o_vga_vs(vs_1), .o_r(r_1), .o_g(g_1), .o_b(b_1),
    .o_frame_start(fs_1), .o_frame_cnt(cnt_1)
  );

  pixel_fetch #(.READ_LATENCY(3), .COLOR_BIT(4), .ADDR_BIT(19)) u_dut3 (
    .clk(clk), .i_rst_n(rst_n),
    .i_hsync_en(hs_en), .i_haddr_en(haddr_en), .i_hidx(hidx),
    .i_vsync_en(vs_en), .i_vaddr_en(vaddr_en), .i_vidx(vidx),
    .o_rd_en(rd_en_3), .o_rd_addr(rd_addr_3), .i_rd_data(rd_data_3),
    .o_vga_hs(hs_3), .o_vga_vs(vs_3), .o_r(r_3), .o_g(g_3), .o_b(b_3),
    .o_frame_start(fs_3), .o_frame_cnt(cnt_3)
  );

  // Framebuffer contents: arbitrary nonzero words, with 1285 holding 0xABC.
  function automatic logic [11:0] ram_word(input logic [18:0] a);
    logic [18:0] x;
    x = a ^ (a >> 7);
    if (a == 19'd1285) return 12'hABC;
    return x[11:0] | 12'h001;
  endfunction

  // RAM models: fixed latency, 0xFFF on the bus when no read is returning.
  logic [19:0] ram1_q [1];
  logic [19:0] ram3_q [3];
  initial begin
    ram1_q[0] = '0;
    for (int i = 0; i < 3; i++) ram3_q[i] = '0;
  end
  always @(posedge clk) ram1_q[0] <= {rd_en_1, rd_addr_1};
  always @(posedge clk) begin
    ram3_q[0] <= {rd_en_3, rd_addr_3};
    ram3_q[1] <= ram3_q[0];
    ram3_q[2] <= ram3_q[1];
  end
  assign rd_data_1 = ram1_q[0][19] ? ram_word(ram1_q[0][18:0]) : 12'hFFF;
  assign rd_data_3 = ram3_q[2][19] ? ram_word(ram3_q[2][18:0]) : 12'hFFF;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per-edge history of what was presented, plus frame state.
  int          t = 0;
  int          last_rst_t = 0;
  bit          h_act [HN];
  bit          h_hs  [HN];
  bit          h_vs  [HN];
  logic [18:0] h_addr[HN];
  logic [18:0] m_addr = '0;
  bit          m_fs = 1'b0;
  bit          m_vsprev = 1'b0;
  int          m_cnt = 0;

  task automatic tick();
    bit a;
    t++;
    if (t >= HN) begin
      $display("FAIL cycle_budget: got %0d edges, limit %0d", t, HN);
      $fatal(1);
    end
    a = rst_n && haddr_en && vaddr_en && int'(hidx) < 640 && int'(vidx) < 480;
    h_act[t]  = a;
    h_addr[t] = 19'(int'(vidx) * 640 + int'(hidx));
    h_hs[t]   = rst_n && hs_en;
    h_vs[t]   = rst_n && vs_en;
    if (!rst_n) begin
      last_rst_t = t; m_addr = '0; m_vsprev = 1'b0; m_cnt = 0; m_fs = 1'b0;
    end else begin
      m_fs     = vs_en && !m_vsprev;
      m_vsprev = vs_en;
      if (m_fs) m_cnt = (m_cnt + 1) % 256;
      if (a) m_addr = h_addr[t];
    end
    @(posedge clk);
    #1;
  endtask

  // Expected pins {hs, vs, rgb} after the current edge for latency L.
  function automatic logic [13:0] exp_pins(input int L);
    int s;
    s = t - (L + 1);
    if (s <= last_rst_t) return {1'b1, 1'b1, 12'h000};
    return {!h_hs[s], !h_vs[s], h_act[s] ? ram_word(h_addr[s]) : 12'h000};
  endfunction

  task automatic set_idle();
    hs_en = 0; vs_en = 0; haddr_en = 0; vaddr_en = 0; hidx = '0; vidx = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({rd_en_1, rd_addr_1, hs_1, vs_1, rgb_1, fs_1, cnt_1} !== {1'b0, 19'd0, 1'b1, 1'b1, 12'd0, 1'b0, 8'd0}) begin
        n_fail++; $display("FAIL reset_hold_1: got %h want %h", {rd_en_1, rd_addr_1, hs_1, vs_1, rgb_1, fs_1, cnt_1}, {1'b0, 19'd0, 1'b1, 1'b1, 12'd0, 1'b0, 8'd0});
      end
      n_chk++;
      if ({rd_en_3, rd_addr_3, hs_3, vs_3, rgb_3, fs_3, cnt_3} !== {1'b0, 19'd0, 1'b1, 1'b1, 12'd0, 1'b0, 8'd0}) begin
        n_fail++; $display("FAIL reset_hold_3: got %h want %h", {rd_en_3, rd_addr_3, hs_3, vs_3, rgb_3, fs_3, cnt_3}, {1'b0, 19'd0, 1'b1, 1'b1, 12'd0, 1'b0, 8'd0});
      end
    end
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({hs_1, vs_1, rgb_1, rd_en_1, fs_1} !== {1'b1, 1'b1, 12'd0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL reset_idle_1 edge %0d: got %h want %h", i, {hs_1, vs_1, rgb_1, rd_en_1, fs_1}, {1'b1, 1'b1, 12'd0, 1'b0, 1'b0});
      end
      n_chk++;
      if ({hs_3, vs_3, rgb_3, rd_en_3, fs_3} !== {1'b1, 1'b1, 12'd0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL reset_idle_3 edge %0d: got %h want %h", i, {hs_3, vs_3, rgb_3, rd_en_3, fs_3}, {1'b1, 1'b1, 12'd0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_single_pixel();
    set_idle();
    haddr_en = 1; vaddr_en = 1; hidx = 10'd5; vidx = 9'd2;
    tick();
    n_chk++;
    if ({rd_en_1, rd_addr_1} !== {1'b1, 19'd1285}) begin
      n_fail++; $display("FAIL pixel_addr_1: got %0d/%0d want 1/1285", rd_en_1, rd_addr_1);
    end
    n_chk++;
    if ({rd_en_3, rd_addr_3} !== {1'b1, 19'd1285}) begin
      n_fail++; $display("FAIL pixel_addr_3: got %0d/%0d want 1/1285", rd_en_3, rd_addr_3);
    end
    set_idle();
    hidx = 10'd77;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_chk++;
      if (rgb_1 !== ((k == 2) ? 12'hABC : 12'h000)) begin
        n_fail++; $display("FAIL pixel_rgb_1 edge+%0d: got %h want %h", k, rgb_1, (k == 2) ? 12'hABC : 12'h000);
      end
      n_chk++;
      if (rgb_3 !== ((k == 4) ? 12'hABC : 12'h000)) begin
        n_fail++; $display("FAIL pixel_rgb_3 edge+%0d: got %h want %h", k, rgb_3, (k == 4) ? 12'hABC : 12'h000);
      end
    end
    n_chk++;
    if ({rd_en_1, rd_addr_1} !== {1'b0, 19'd1285}) begin
      n_fail++; $display("FAIL addr_hold: got %0d/%0d want 0/1285", rd_en_1, rd_addr_1);
    end
  endtask

  task automatic test_last_pixel();
    logic [11:0] w;
    w = ram_word(19'd307199);
    set_idle();
    haddr_en = 1; vaddr_en = 1; hidx = 10'd639; vidx = 9'd479;
    tick();
    n_chk++;
    if ({rd_en_1, rd_addr_1} !== {1'b1, 19'd307199}) begin
      n_fail++; $display("FAIL last_addr_1: got %0d/%0d want 1/307199", rd_en_1, rd_addr_1);
    end
    n_chk++;
    if ({rd_en_3, rd_addr_3} !== {1'b1, 19'd307199}) begin
      n_fail++; $display("FAIL last_addr_3: got %0d/%0d want 1/307199", rd_en_3, rd_addr_3);
    end
    haddr_en = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        n_chk++;
        if ({rd_en_1, rd_addr_1} !== {1'b0, 19'd307199}) begin
          n_fail++; $display("FAIL last_next_rd: got %0d/%0d want 0/307199", rd_en_1, rd_addr_1);
        end
      end
      n_chk++;
      if (rgb_1 !== ((k == 2) ? w : 12'h000)) begin
        n_fail++; $display("FAIL last_rgb_1 edge+%0d: got %h want %h", k, rgb_1, (k == 2) ? w : 12'h000);
      end
      n_chk++;
      if (rgb_3 !== ((k == 4) ? w : 12'h000)) begin
        n_fail++; $display("FAIL last_rgb_3 edge+%0d: got %h want %h", k, rgb_3, (k == 4) ? w : 12'h000);
      end
    end
  endtask

  task automatic test_hsync();
    int first1, first3, low1, low3;
    first1 = 0; first3 = 0; low1 = 0; low3 = 0;
    set_idle();
    for (int j = 1; j <= 110; j++) begin
      hs_en = (j <= 96);
      tick();
      if (hs_1 === 1'b0) begin low1++; if (first1 == 0) first1 = j; end
      if (hs_3 === 1'b0) begin low3++; if (first3 == 0) first3 = j; end
    end
    n_chk++;
    if (first3 != 5 || low3 != 96) begin
      n_fail++; $display("FAIL hsync_3: got start %0d width %0d want start 5 width 96", first3, low3);
    end
    n_chk++;
    if (first1 != 3 || low1 != 96) begin
      n_fail++; $display("FAIL hsync_1: got start %0d width %0d want start 3 width 96", first1, low1);
    end
  endtask

  task automatic test_random();
    set_idle();
    for (int i = 0; i < 400; i++) begin
      haddr_en = ($urandom_range(0, 3) != 0);
      vaddr_en = ($urandom_range(0, 5) != 0);
      hidx = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
      vidx = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 479));
      if ($urandom_range(0, 7) == 0) hs_en = ~hs_en;
      if ($urandom_range(0, 11) == 0) vs_en = ~vs_en;
      tick();
      n_chk++;
      if ({hs_1, vs_1, rgb_1} !== exp_pins(1)) begin
        n_fail++; $display("FAIL rand_pins_1 t=%0d: got %h want %h", t, {hs_1, vs_1, rgb_1}, exp_pins(1));
      end
      n_chk++;
      if ({hs_3, vs_3, rgb_3} !== exp_pins(3)) begin
        n_fail++; $display("FAIL rand_pins_3 t=%0d: got %h want %h", t, {hs_3, vs_3, rgb_3}, exp_pins(3));
      end
      n_chk++;
      if ({rd_en_1, rd_addr_1} !== {h_act[t], m_addr} || {rd_en_3, rd_addr_3} !== {h_act[t], m_addr}) begin
        n_fail++; $display("FAIL rand_rd t=%0d: got %0d/%0d and %0d/%0d want %0d/%0d", t, rd_en_1, rd_addr_1, rd_en_3, rd_addr_3, h_act[t], m_addr);
      end
      n_chk++;
      if ({fs_1, cnt_1, fs_3, cnt_3} !== {m_fs, 8'(m_cnt), m_fs, 8'(m_cnt)}) begin
        n_fail++; $display("FAIL rand_frame t=%0d: got %0d/%0d and %0d/%0d want %0d/%0d", t, fs_1, cnt_1, fs_3, cnt_3, m_fs, m_cnt);
      end
    end
  endtask

  task automatic test_reset_midframe();
    set_idle();
    haddr_en = 1; vaddr_en = 1; hs_en = 1;
    for (int i = 0; i < 8; i++) begin
      hidx = 10'($urandom_range(0, 639)); vidx = 9'($urandom_range(0, 479));
      tick();
    end
    n_chk++;
    if ({hs_3, vs_3, rgb_3} !== exp_pins(3) || rgb_3 === 12'h000) begin
      n_fail++; $display("FAIL midrst_pre: got %h want %h (nonzero colour)", {hs_3, vs_3, rgb_3}, exp_pins(3));
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({hs_1, vs_1, rgb_1, rd_en_1, hs_3, vs_3, rgb_3, rd_en_3} !== {1'b1, 1'b1, 12'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0}) begin
      n_fail++; $display("FAIL midrst_async: got %h want %h", {hs_1, vs_1, rgb_1, rd_en_1, hs_3, vs_3, rgb_3, rd_en_3}, {1'b1, 1'b1, 12'd0, 1'b0, 1'b1, 1'b1, 12'd0, 1'b0});
    end
    tick();
    tick();
    rst_n = 1;
    for (int k = 1; k <= 7; k++) begin
      hidx = 10'($urandom_range(0, 639)); vidx = 9'($urandom_range(0, 479));
      tick();
      if (k < 3) begin
        n_chk++;
        if ({hs_1, rgb_1} !== {1'b1, 12'd0}) begin
          n_fail++; $display("FAIL midrst_refill_1 edge %0d: got %h want %h", k, {hs_1, rgb_1}, {1'b1, 12'd0});
        end
      end
      if (k < 5) begin
        n_chk++;
        if ({hs_3, rgb_3} !== {1'b1, 12'd0}) begin
          n_fail++; $display("FAIL midrst_refill_3 edge %0d: got %h want %h", k, {hs_3, rgb_3}, {1'b1, 12'd0});
        end
      end
      n_chk++;
      if ({hs_1, vs_1, rgb_1} !== exp_pins(1) || {hs_3, vs_3, rgb_3} !== exp_pins(3)) begin
        n_fail++; $display("FAIL midrst_model edge %0d: got %h/%h want %h/%h", k, {hs_1, vs_1, rgb_1}, {hs_3, vs_3, rgb_3}, exp_pins(1), exp_pins(3));
      end
    end
  endtask

  task automatic test_frames();
    int pulses;
    set_idle();
    rst_n = 0;
    vs_en = 1;
    tick();
    rst_n = 1;
    tick();
    n_chk++;
    if ({fs_1, cnt_1, fs_3, cnt_3} !== {1'b1, 8'd1, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL frame_first: got %0d/%0d %0d/%0d want 1/1 1/1", fs_1, cnt_1, fs_3, cnt_3);
    end
    pulses = 1;
    tick();
    for (int f = 0; f < 256; f++) begin
      for (int p = 0; p < 4; p++) begin
        vs_en = (p >= 2);
        tick();
        if (fs_1 === 1'b1) pulses++;
        n_chk++;
        if ({fs_1, cnt_1, fs_3, cnt_3} !== {m_fs, 8'(m_cnt), m_fs, 8'(m_cnt)}) begin
          n_fail++; $display("FAIL frame_track t=%0d: got %0d/%0d %0d/%0d want %0d/%0d", t, fs_1, cnt_1, fs_3, cnt_3, m_fs, m_cnt);
        end
      end
    end
    n_chk++;
    if (pulses != 257 || cnt_1 !== 8'd1 || cnt_3 !== 8'd1) begin
      n_fail++; $display("FAIL frame_wrap: got %0d pulses cnt %0d/%0d want 257 pulses cnt 1/1", pulses, cnt_1, cnt_3);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_last_pixel();
    test_hsync();
    test_random();
    test_reset_midframe();
    test_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Downstream stage of the horizontal and vertical sync counters. It merges their sync and address-enable strobes and pixel indices, and issues framebuffer read requests (address = row·640 + column). It realigns the returned RGB data with delayed, pin-polarity sync outputs, so the VGA connector sees pixels and sync edges with a fixed, matched latency. It also produces a one-cycle frame-start pulse and a free-running frame counter for software and animation logic.

## Interface
Parameters:
- READ_LATENCY, 1, framebuffer read latency in clock edges from sampled o_rd_en to valid i_rd_data; legal range 1..4.
- COLOR_BIT, 4, bits per colour channel.
- ADDR_BIT, 19, framebuffer address width (640·480 = 307200 words).

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal); single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_hsync_en  in  1  high during horizontal sync pulse.
- i_haddr_en  in  1  high during visible columns.
- i_hidx  in  10  visible column index, 0..639, meaningful when i_haddr_en=1.
- i_vsync_en  in  1  high during vertical sync pulse (first 2 lines of frame).
- i_vaddr_en  in  1  high during visible lines.
- i_vidx  in  9  visible row index, 0..479, meaningful when i_vaddr_en=1.
- o_rd_en  out  1  framebuffer read strobe.
- o_rd_addr  out  ADDR_BIT  framebuffer word address.
- i_rd_data  in  3·COLOR_BIT  {R,G,B} returned READ_LATENCY edges after o_rd_en.
- o_vga_hs  out  1  horizontal sync, active-low at pin.
- o_vga_vs  out  1  vertical sync, active-low at pin.
- o_r, o_g, o_b  out  COLOR_BIT each  pixel colour; zero when blanked.
- o_frame_start  out  1  one-cycle pulse per frame.
- o_frame_cnt  out  8  frame counter, wraps 255→0.

## Operation
- Stage A (registered): active = i_haddr_en & i_vaddr_en & (i_hidx < 640) & (i_vidx < 480). o_rd_en <= active. o_rd_addr <= (i_vidx<<9) + (i_vidx<<7) + i_hidx when active; otherwise it holds its previous value.
- Address arithmetic is unsigned, ADDR_BIT wide. Maximum is 479·640+639 = 307199; no overflow is possible.
- Out-of-range indices while the enables are high are treated as blank: no read is issued and the pixel outputs zero.
- Delay line: {active, i_hsync_en, i_vsync_en} are delayed by READ_LATENCY+1 edges, matching Stage A plus the RAM latency.
- Output stage (registered): o_vga_hs <= ~hs_d and o_vga_vs <= ~vs_d. {o_r,o_g,o_b} <= active_d ? i_rd_data : 0.
- Frame tracking: vs_prev <= i_vsync_en. o_frame_start <= i_vsync_en & ~vs_prev. o_frame_cnt increments on the same edge that sets o_frame_start, modulo 256.
- No backpressure: the RAM must accept one read per cycle and return data in order.

## Timing
- Input-to-pin latency: READ_LATENCY+2 edges, identical for colour, hs and vs. This preserves the upstream porch and sync alignment exactly.
- o_rd_en/o_rd_addr: 1 edge after the inputs.
- o_frame_start: 1 edge after the i_vsync_en rise. It is not delayed to pin alignment.
- Reset values: o_rd_en=0, o_rd_addr=0, o_vga_hs=1, o_vga_vs=1, colours=0, o_frame_start=0, o_frame_cnt=0. All delay-line stages clear to 0 (blank, sync inactive).
- Reset mid-frame: outputs go to reset values immediately (asynchronous). After release, the pipeline refills over READ_LATENCY+2 edges with blank, inactive sync. No spurious sync pulse or stale pixel may appear.
- i_vsync_en already high at reset release: vs_prev resets to 0, so a frame_start pulse fires on the first edge. This is intended.
- Simultaneous hsync and vsync pulses pass through independently. Colour is forced to 0 whenever active_d=0, regardless of i_rd_data.

## Structure
- Shared package vga_pkg: H_VISIBLE=640, V_VISIBLE=480, FB_ADDR_BIT=19, COLOR_BIT=4, and the {R,G,B} packing order.
- Sub-module delayN (parameters WIDTH, DEPTH; async active-low reset to 0): used for the 3-bit active/hs/vs delay line.
- Address multiply uses shift-add only; no DSP inference.

## Test plan
- Reset held, then released with idle inputs -> all outputs at reset values; o_vga_hs=o_vga_vs=1 for every cycle up to READ_LATENCY+2.
- Pixel (hidx=5, vidx=2), both addr_en high, READ_LATENCY=1 -> o_rd_en=1 and o_rd_addr=1285 after 1 edge. RAM model returns 0xABC -> {o_r,o_g,o_b}=0xA,0xB,0xC exactly 3 edges after the input.
- Last pixel (639,479) -> o_rd_addr=307199. Next cycle with i_haddr_en=0 -> o_rd_en=0 and colour 0 at the matching output cycle, even though the RAM drives 0xFFF.
- i_hsync_en high 96 cycles, READ_LATENCY=3 -> o_vga_hs low for exactly 96 cycles, starting 5 edges after the input rise.
- 257 i_vsync_en rising edges -> 257 single-cycle o_frame_start pulses; o_frame_cnt reads 1 after the first and 1 again after the 257th (wrap).
- i_rst_n asserted mid-line during visible pixels -> colours 0 and syncs 1 immediately. After release, no nonzero colour appears before READ_LATENCY+2 edges.
